// File: rtl/path_feeder.sv
// Path-sample source for the pricing core: RAM of DAYS x PATHS_PER_DAY samples,
// streamed day by day with a two-pass resend handshake, plus price capture.
module path_feeder #(
    parameter int unsigned DATA_W        = 12,
    parameter int unsigned PATHS_PER_DAY = 256,
    parameter int unsigned DAYS          = 8,
    parameter int unsigned ADDR_W        = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    input  logic [DATA_W-1:0] k_cfg,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic              core_start,
    output logic [DATA_W-1:0] path,
    output logic [DATA_W-1:0] K,
    input  logic              resend,
    input  logic              valid,
    input  logic [DATA_W-1:0] price,
    output logic [DATA_W-1:0] price_q,
    output logic [3:0]        price_cnt,
    output logic [2:0]        day_idx,
    output logic              pass,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned IDX_W = $clog2(PATHS_PER_DAY + 1);
    localparam int unsigned DAY_W = 3;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    localparam logic [IDX_W-1:0] IDX_END  = IDX_W'(PATHS_PER_DAY);
    localparam logic [DAY_W-1:0] DAY_LAST = DAY_W'(DAYS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_STREAM = 3'd2,
        S_WAIT   = 3'd3,
        S_DONE   = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] k_q, k_d;
    logic [DAY_W-1:0]  day_q, day_d;
    logic              pass_q, pass_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] cap_price_q, cap_price_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              core_start_q, core_start_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] rd_q;

    logic              rd_en_c;
    logic [ADDR_W-1:0] rd_addr_c;
    logic              wr_en_c;
    logic              clr_c;

    logic [DATA_W-1:0] mem [DEPTH];

    // Flat word address of sample idx within a day.
    function automatic logic [ADDR_W-1:0] word_addr(input logic [DAY_W-1:0] day,
                                                    input logic [IDX_W-1:0] idx);
        return ADDR_W'(day) * ADDR_W'(PATHS_PER_DAY) + ADDR_W'(idx);
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (go) state_d = S_START;
            S_START:  state_d = S_STREAM;
            S_STREAM: if (idx_q == IDX_END) state_d = S_WAIT;
            S_WAIT: begin
                if (resend) begin
                    if (pass_q && (day_q == DAY_LAST)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_STREAM;
                    end
                end
            end
            S_DONE:   if (go) state_d = S_START;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output and datapath next values; a pass restart issues word 0 immediately.
    always_comb begin
        k_d       = k_q;
        day_d     = day_q;
        pass_d    = pass_q;
        idx_d     = idx_q;
        err_d     = err_q;
        rd_en_c   = 1'b0;
        rd_addr_c = '0;
        wr_en_c   = 1'b0;
        clr_c     = 1'b0;

        case (state_q)
            S_IDLE: begin
                wr_en_c = load_en;
                clr_c   = go;
            end
            S_START: begin
                rd_en_c   = 1'b1;
                rd_addr_c = word_addr(day_q, '0);
                idx_d     = IDX_W'(1);
            end
            S_STREAM: begin
                if (idx_q != IDX_END) begin
                    rd_en_c   = 1'b1;
                    rd_addr_c = word_addr(day_q, idx_q);
                    idx_d     = idx_q + IDX_W'(1);
                end
                if (resend) begin
                    err_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (resend) begin
                    if (!pass_q) begin
                        pass_d    = 1'b1;
                        rd_en_c   = 1'b1;
                        rd_addr_c = word_addr(day_q, '0);
                        idx_d     = IDX_W'(1);
                    end else if (day_q != DAY_LAST) begin
                        day_d     = day_q + DAY_W'(1);
                        pass_d    = 1'b0;
                        rd_en_c   = 1'b1;
                        rd_addr_c = word_addr(day_q + DAY_W'(1), '0);
                        idx_d     = IDX_W'(1);
                    end
                end
            end
            S_DONE: begin
                clr_c = go;
            end
            default: begin
                clr_c = 1'b0;
            end
        endcase

        if (clr_c) begin
            k_d    = k_cfg;
            day_d  = '0;
            pass_d = 1'b0;
            err_d  = 1'b0;
        end

        cap_price_d = cap_price_q;
        cnt_d       = clr_c ? '0 : cnt_q;
        if (valid) begin
            cap_price_d = price;
            if (clr_c) begin
                cnt_d = CNT_W'(1);
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        core_start_d = (state_d == S_START);
        busy_d       = (state_d == S_START) || (state_d == S_STREAM) || (state_d == S_WAIT);
        done_d       = (state_d == S_DONE);
    end

    // Registered outputs and datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            k_q          <= '0;
            day_q        <= '0;
            pass_q       <= 1'b0;
            idx_q        <= '0;
            err_q        <= 1'b0;
            cap_price_q  <= '0;
            cnt_q        <= '0;
            core_start_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            rd_q         <= '0;
        end else begin
            k_q          <= k_d;
            day_q        <= day_d;
            pass_q       <= pass_d;
            idx_q        <= idx_d;
            err_q        <= err_d;
            cap_price_q  <= cap_price_d;
            cnt_q        <= cnt_d;
            core_start_q <= core_start_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            if (rd_en_c) begin
                rd_q <= mem[rd_addr_c];
            end
        end
    end

    // Sample RAM write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem[load_addr] <= load_data;
        end
    end

    assign core_start = core_start_q;
    assign path       = rd_q;
    assign K          = k_q;
    assign price_q    = cap_price_q;
    assign price_cnt  = cnt_q;
    assign day_idx    = day_q;
    assign pass       = pass_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_path_feeder.sv
// Directed bench for path_feeder with 2 days x 4 samples per day.
module tb_path_feeder;

    localparam int unsigned DATA_W = 12;
    localparam int unsigned ADDR_W = 11;

    logic              clk = 1'b0;
    logic              rst;
    logic              go;
    logic [DATA_W-1:0] k_cfg;
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;
    logic              core_start;
    logic [DATA_W-1:0] path;
    logic [DATA_W-1:0] K;
    logic              resend;
    logic              valid;
    logic [DATA_W-1:0] price;
    logic [DATA_W-1:0] price_q;
    logic [3:0]        price_cnt;
    logic [2:0]        day_idx;
    logic              pass;
    logic              busy;
    logic              done;
    logic              err;

    int errors = 0;
    int checks = 0;
    int seen [8];

    path_feeder #(
        .DATA_W(DATA_W), .PATHS_PER_DAY(4), .DAYS(2), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst(rst), .go(go), .k_cfg(k_cfg),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .core_start(core_start), .path(path), .K(K),
        .resend(resend), .valid(valid), .price(price),
        .price_q(price_q), .price_cnt(price_cnt), .day_idx(day_idx),
        .pass(pass), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic note_seen;
        if (path >= 12'h100 && path < 12'h108) seen[int'(path - 12'h100)]++;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick;
        tick;
        checks++;
        if ({core_start, path, K, price_q, price_cnt, day_idx, pass, busy, done, err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got start=%b path=%h K=%h pq=%h cnt=%0d day=%0d pass=%b busy=%b done=%b err=%b expected all zero",
                     core_start, path, K, price_q, price_cnt, day_idx, pass, busy, done, err);
        end
        rst = 1'b0;
    endtask

    task automatic load_ram;
        for (int a = 0; a < 8; a++) begin
            load_en   = 1'b1;
            load_addr = ADDR_W'(a);
            load_data = 12'h100 + DATA_W'(a);
            tick;
        end
        load_en = 1'b0;
    endtask

    task automatic test_first_pass;
        go = 1'b1;
        k_cfg = 12'h300;
        tick;
        go = 1'b0;
        checks++;
        if (core_start !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL start_pulse: got start=%b busy=%b expected 1 1", core_start, busy);
        end
        for (int k = 0; k < 4; k++) begin
            tick;
            note_seen;
            checks++;
            if (path !== 12'h100 + DATA_W'(k) || core_start !== 1'b0) begin
                errors++;
                $display("FAIL first_pass_w%0d: got path=%h start=%b expected %h 0", k, path, core_start, 12'h100 + DATA_W'(k));
            end
        end
        tick;
        checks++;
        if (path !== 12'h103 || K !== 12'h300 || busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL wait_hold: got path=%h K=%h busy=%b done=%b expected 103 300 1 0", path, K, busy, done);
        end
        tick;
        checks++;
        if (path !== 12'h103) begin
            errors++;
            $display("FAIL wait_steady: got path=%h expected 103", path);
        end
    endtask

    task automatic test_replay;
        resend = 1'b1;
        tick;
        resend = 1'b0;
        for (int k = 0; k < 4; k++) begin
            note_seen;
            checks++;
            if (path !== 12'h100 + DATA_W'(k) || pass !== 1'b1 || day_idx !== 3'd0 || core_start !== 1'b0) begin
                errors++;
                $display("FAIL replay_w%0d: got path=%h pass=%b day=%0d start=%b expected %h 1 0 0",
                         k, path, pass, day_idx, core_start, 12'h100 + DATA_W'(k));
            end
            tick;
        end
        checks++;
        if (path !== 12'h103 || err !== 1'b0) begin
            errors++;
            $display("FAIL replay_end: got path=%h err=%b expected 103 0", path, err);
        end
    endtask

    task automatic test_day_advance;
        for (int p = 0; p < 2; p++) begin
            resend = 1'b1;
            tick;
            resend = 1'b0;
            for (int k = 0; k < 4; k++) begin
                note_seen;
                checks++;
                if (path !== 12'h104 + DATA_W'(k) || pass !== 1'(p) || day_idx !== 3'd1 || core_start !== 1'b0) begin
                    errors++;
                    $display("FAIL day1_p%0d_w%0d: got path=%h pass=%b day=%0d start=%b expected %h %0d 1 0",
                             p, k, path, pass, day_idx, core_start, 12'h104 + DATA_W'(k), p);
                end
                tick;
            end
        end
        resend = 1'b1;
        tick;
        resend = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || path !== 12'h107 || core_start !== 1'b0) begin
            errors++;
            $display("FAIL done_state: got done=%b busy=%b path=%h start=%b expected 1 0 107 0", done, busy, path, core_start);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (seen[i] !== 2) begin
                errors++;
                $display("FAIL stream_count_%0d: got %0d expected 2", i, seen[i]);
            end
        end
    endtask

    task automatic test_err;
        go = 1'b1;
        tick;
        go = 1'b0;
        checks++;
        if (core_start !== 1'b1 || done !== 1'b0 || err !== 1'b0 || day_idx !== 3'd0 || pass !== 1'b0) begin
            errors++;
            $display("FAIL restart_from_done: got start=%b done=%b err=%b day=%0d pass=%b expected 1 0 0 0 0",
                     core_start, done, err, day_idx, pass);
        end
        tick;
        tick;
        tick;
        checks++;
        if (path !== 12'h102 || err !== 1'b0) begin
            errors++;
            $display("FAIL err_pre: got path=%h err=%b expected 102 0", path, err);
        end
        resend = 1'b1;
        tick;
        resend = 1'b0;
        checks++;
        if (path !== 12'h103 || err !== 1'b1) begin
            errors++;
            $display("FAIL err_set: got path=%h err=%b expected 103 1", path, err);
        end
        tick;
        checks++;
        if (path !== 12'h103 || err !== 1'b1 || pass !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL err_wait: got path=%h err=%b pass=%b busy=%b expected 103 1 0 1", path, err, pass, busy);
        end
    endtask

    task automatic test_price;
        checks++;
        if (price_cnt !== 4'd0) begin
            errors++;
            $display("FAIL price_cnt_cleared: got %0d expected 0", price_cnt);
        end
        price = 12'h2A5;
        valid = 1'b1;
        tick;
        valid = 1'b0;
        checks++;
        if (price_q !== 12'h2A5 || price_cnt !== 4'd1) begin
            errors++;
            $display("FAIL price_1: got pq=%h cnt=%0d expected 2a5 1", price_q, price_cnt);
        end
        tick;
        valid = 1'b1;
        resend = 1'b1;
        tick;
        valid = 1'b0;
        resend = 1'b0;
        checks++;
        if (price_cnt !== 4'd2 || path !== 12'h100 || pass !== 1'b1) begin
            errors++;
            $display("FAIL price_with_resend: got cnt=%0d path=%h pass=%b expected 2 100 1", price_cnt, path, pass);
        end
        valid = 1'b1;
        tick;
        valid = 1'b0;
        checks++;
        if (price_q !== 12'h2A5 || price_cnt !== 4'd3 || path !== 12'h101) begin
            errors++;
            $display("FAIL price_3: got pq=%h cnt=%0d path=%h expected 2a5 3 101", price_q, price_cnt, path);
        end
        tick;
        tick;
        tick;
        resend = 1'b1;
        tick;
        resend = 1'b0;
        checks++;
        if (path !== 12'h104 || day_idx !== 3'd1 || pass !== 1'b0) begin
            errors++;
            $display("FAIL day1_enter: got path=%h day=%0d pass=%b expected 104 1 0", path, day_idx, pass);
        end
    endtask

    task automatic test_reset_mid;
        load_en   = 1'b1;
        load_addr = ADDR_W'(1);
        load_data = 12'hFFF;
        tick;
        checks++;
        if (path !== 12'h105) begin
            errors++;
            $display("FAIL mid_stream: got path=%h expected 105", path);
        end
        load_addr = ADDR_W'(4);
        load_data = 12'hEEE;
        tick;
        load_en = 1'b0;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        checks++;
        if ({core_start, path, K, price_q, price_cnt, day_idx, pass, busy, done, err} !== '0) begin
            errors++;
            $display("FAIL mid_reset: got start=%b path=%h K=%h pq=%h cnt=%0d day=%0d pass=%b busy=%b done=%b err=%b expected all zero",
                     core_start, path, K, price_q, price_cnt, day_idx, pass, busy, done, err);
        end
        tick;
        checks++;
        if (core_start !== 1'b0 || busy !== 1'b0 || path !== 12'h000) begin
            errors++;
            $display("FAIL mid_reset_idle: got start=%b busy=%b path=%h expected 0 0 000", core_start, busy, path);
        end
    endtask

    task automatic test_price_sat;
        valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            price = 12'h010 + DATA_W'(i);
            tick;
            if (i == 14) begin
                checks++;
                if (price_cnt !== 4'd15) begin
                    errors++;
                    $display("FAIL cnt_reach_15: got %0d expected 15", price_cnt);
                end
            end
        end
        valid = 1'b0;
        checks++;
        if (price_cnt !== 4'd15 || price_q !== 12'h01F) begin
            errors++;
            $display("FAIL cnt_saturate: got cnt=%0d pq=%h expected 15 01f", price_cnt, price_q);
        end
    endtask

    task automatic test_restart;
        go        = 1'b1;
        k_cfg     = 12'h155;
        load_en   = 1'b1;
        load_addr = ADDR_W'(0);
        load_data = 12'h0AB;
        tick;
        go      = 1'b0;
        load_en = 1'b0;
        checks++;
        if (core_start !== 1'b1 || price_cnt !== 4'd0 || K !== 12'h155 || day_idx !== 3'd0) begin
            errors++;
            $display("FAIL restart_go: got start=%b cnt=%0d K=%h day=%0d expected 1 0 155 0", core_start, price_cnt, K, day_idx);
        end
        tick;
        checks++;
        if (path !== 12'h0AB) begin
            errors++;
            $display("FAIL load_with_go: got path=%h expected 0ab", path);
        end
        tick;
        checks++;
        if (path !== 12'h101) begin
            errors++;
            $display("FAIL load_ignored_busy: got path=%h expected 101", path);
        end
        tick;
        tick;
        tick;
        resend = 1'b1;
        tick;
        resend = 1'b0;
        tick;
        tick;
        tick;
        tick;
        resend = 1'b1;
        tick;
        resend = 1'b0;
        checks++;
        if (path !== 12'h104 || day_idx !== 3'd1) begin
            errors++;
            $display("FAIL load_ignored_day1: got path=%h day=%0d expected 104 1", path, day_idx);
        end
    endtask

    initial begin
        rst       = 1'b1;
        go        = 1'b0;
        k_cfg     = '0;
        load_en   = 1'b0;
        load_addr = '0;
        load_data = '0;
        resend    = 1'b0;
        valid     = 1'b0;
        price     = '0;
        for (int i = 0; i < 8; i++) seen[i] = 0;

        test_reset;
        load_ram;
        test_first_pass;
        test_replay;
        test_day_advance;
        test_err;
        test_price;
        test_reset_mid;
        test_price_sat;
        test_restart;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
